// File: rtl/alu_pipeline_core.sv
// Five-stage RV32I ALU-subset pipeline (IF, ID, EX, M, WB) with parametrised width.
// Define FORWARDING_EN for EX-stage bypassing; otherwise ID interlocks on RAW hazards.
module alu_pipeline_core #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall_in,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data
);

    typedef enum logic [2:0] {OpAdd, OpSub, OpXor, OpOr, OpAnd} alu_op_e;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    // Fetch stage
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q;
    logic [31:0]     if_instr_q;

    // Decode stage
    logic [6:0]      id_opcode, id_funct7;
    logic [2:0]      id_funct3;
    logic [4:0]      id_rd, id_rs1, id_rs2;
    logic            id_legal, id_valid, id_is_r;
    alu_op_e         id_op;
    logic [XLEN-1:0] id_imm, id_rs1_val, id_rs2_val;
    logic            interlock;

    // Register file
    logic [XLEN-1:0] rf_q [32];
    logic            wb_we;

    // ID/EX
    logic            id_ex_valid_q;
    alu_op_e         id_ex_op_q;
    logic [4:0]      id_ex_rd_q;
    logic [XLEN-1:0] id_ex_a_q, id_ex_b_q;
`ifdef FORWARDING_EN
    logic [4:0]      id_ex_rs1_q, id_ex_rs2_q;
    logic            id_ex_use_rs2_q;
`endif

    // Execute
    logic [XLEN-1:0] ex_a, ex_b, ex_result;

    // EX/M and M/WB
    logic            ex_m_valid_q, m_wb_valid_q;
    logic [4:0]      ex_m_rd_q, m_wb_rd_q;
    logic [XLEN-1:0] ex_m_res_q, m_wb_res_q;

    assign imem_addr = pc_q;
    assign pc_d      = interlock ? pc_q : pc_q + XLEN'(4);

    assign id_opcode = if_instr_q[6:0];
    assign id_rd     = if_instr_q[11:7];
    assign id_funct3 = if_instr_q[14:12];
    assign id_rs1    = if_instr_q[19:15];
    assign id_rs2    = if_instr_q[24:20];
    assign id_funct7 = if_instr_q[31:25];
    assign id_imm    = {{(XLEN-12){if_instr_q[31]}}, if_instr_q[31:20]};

    always_comb begin
        id_legal = 1'b0;
        id_is_r  = 1'b0;
        id_op    = OpAdd;
        if (id_opcode == OpcOp) begin
            id_is_r = 1'b1;
            case (id_funct3)
                3'b000: begin
                    id_legal = (id_funct7 == 7'b0000000) || (id_funct7 == 7'b0100000);
                    id_op    = id_funct7[5] ? OpSub : OpAdd;
                end
                3'b100: begin
                    id_legal = (id_funct7 == 7'b0000000);
                    id_op    = OpXor;
                end
                3'b110: begin
                    id_legal = (id_funct7 == 7'b0000000);
                    id_op    = OpOr;
                end
                3'b111: begin
                    id_legal = (id_funct7 == 7'b0000000);
                    id_op    = OpAnd;
                end
                default: ;
            endcase
        end else if (id_opcode == OpcOpImm) begin
            case (id_funct3)
                3'b000: begin id_legal = 1'b1; id_op = OpAdd; end
                3'b100: begin id_legal = 1'b1; id_op = OpXor; end
                3'b110: begin id_legal = 1'b1; id_op = OpOr;  end
                3'b111: begin id_legal = 1'b1; id_op = OpAnd; end
                default: ;
            endcase
        end
    end

    assign id_valid = if_valid_q && id_legal;

    // WB writes land at the end of the cycle, so ID bypasses them to see the new value.
    assign wb_we = m_wb_valid_q && (m_wb_rd_q != 5'd0) && !stall_in;

    always_comb begin
        id_rs1_val = rf_q[id_rs1];
        id_rs2_val = rf_q[id_rs2];
        if (id_rs1 == 5'd0) begin
            id_rs1_val = '0;
        end else if (wb_we && (m_wb_rd_q == id_rs1)) begin
            id_rs1_val = m_wb_res_q;
        end
        if (id_rs2 == 5'd0) begin
            id_rs2_val = '0;
        end else if (wb_we && (m_wb_rd_q == id_rs2)) begin
            id_rs2_val = m_wb_res_q;
        end
    end

`ifdef FORWARDING_EN
    assign interlock = 1'b0;
`else
    logic rs1_hazard, rs2_hazard;

    // Producers in EX or M are not yet visible to ID; WB is covered by write-through.
    assign rs1_hazard = id_valid && (id_rs1 != 5'd0) &&
                        ((id_ex_valid_q && (id_ex_rd_q == id_rs1)) ||
                         (ex_m_valid_q && (ex_m_rd_q == id_rs1)));
    assign rs2_hazard = id_valid && id_is_r && (id_rs2 != 5'd0) &&
                        ((id_ex_valid_q && (id_ex_rd_q == id_rs2)) ||
                         (ex_m_valid_q && (ex_m_rd_q == id_rs2)));
    assign interlock  = rs1_hazard || rs2_hazard;
`endif

    always_comb begin
        ex_a = id_ex_a_q;
        ex_b = id_ex_b_q;
`ifdef FORWARDING_EN
        if (ex_m_valid_q && (ex_m_rd_q != 5'd0) && (ex_m_rd_q == id_ex_rs1_q)) begin
            ex_a = ex_m_res_q;
        end else if (m_wb_valid_q && (m_wb_rd_q != 5'd0) && (m_wb_rd_q == id_ex_rs1_q)) begin
            ex_a = m_wb_res_q;
        end
        // I-type b holds the immediate and is never bypassed.
        if (id_ex_use_rs2_q) begin
            if (ex_m_valid_q && (ex_m_rd_q != 5'd0) && (ex_m_rd_q == id_ex_rs2_q)) begin
                ex_b = ex_m_res_q;
            end else if (m_wb_valid_q && (m_wb_rd_q != 5'd0) &&
                         (m_wb_rd_q == id_ex_rs2_q)) begin
                ex_b = m_wb_res_q;
            end
        end
`endif
        ex_result = '0;
        case (id_ex_op_q)
            OpAdd:   ex_result = ex_a + ex_b;
            OpSub:   ex_result = ex_a - ex_b;
            OpXor:   ex_result = ex_a ^ ex_b;
            OpOr:    ex_result = ex_a | ex_b;
            OpAnd:   ex_result = ex_a & ex_b;
            default: ex_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            id_ex_valid_q <= 1'b0;
            id_ex_op_q    <= OpAdd;
            id_ex_rd_q    <= '0;
            id_ex_a_q     <= '0;
            id_ex_b_q     <= '0;
`ifdef FORWARDING_EN
            id_ex_rs1_q     <= '0;
            id_ex_rs2_q     <= '0;
            id_ex_use_rs2_q <= 1'b0;
`endif
            ex_m_valid_q  <= 1'b0;
            ex_m_rd_q     <= '0;
            ex_m_res_q    <= '0;
            m_wb_valid_q  <= 1'b0;
            m_wb_rd_q     <= '0;
            m_wb_res_q    <= '0;
        end else if (!stall_in) begin
            pc_q <= pc_d;
            if (!interlock) begin
                if_valid_q <= 1'b1;
                if_instr_q <= imem_rdata;
            end
            id_ex_valid_q <= id_valid && !interlock;
            id_ex_op_q    <= id_op;
            id_ex_rd_q    <= id_rd;
            id_ex_a_q     <= id_rs1_val;
            id_ex_b_q     <= id_is_r ? id_rs2_val : id_imm;
`ifdef FORWARDING_EN
            id_ex_rs1_q     <= id_rs1;
            id_ex_rs2_q     <= id_rs2;
            id_ex_use_rs2_q <= id_is_r;
`endif
            ex_m_valid_q  <= id_ex_valid_q;
            ex_m_rd_q     <= id_ex_rd_q;
            ex_m_res_q    <= ex_result;
            m_wb_valid_q  <= ex_m_valid_q;
            m_wb_rd_q     <= ex_m_rd_q;
            m_wb_res_q    <= ex_m_res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we) begin
            rf_q[m_wb_rd_q] <= m_wb_res_q;
        end
    end

    assign retire_valid = m_wb_valid_q && !stall_in;
    assign retire_rd    = retire_valid ? m_wb_rd_q : 5'd0;
    assign retire_data  = retire_valid ? m_wb_res_q : '0;

endmodule
